// File: rtl/medidor_distancia_bcd.sv
// Purpose: ultrasonic echo-width to BCD distance converter (prescaler + BCD counter + FSM).
// Latency: pronto rises 3 clocks after the echo pin falls (2-FF sync + 1 registered FSM step).
// Backpressure: none; medir is only honoured in IDLE/FIM, and the result is held until the next accepted medir.
//
// Ports:
//   clock     - system clock, rising edge
//   reset     - asynchronous, active-low; clears all state
//   medir     - start request (sampled in IDLE/FIM only)
//   echo      - raw, asynchronous sensor echo
//   pronto    - result valid (level)
//   timeout   - no echo rise within TIMEOUT clocks of the accepted medir
//   saturado  - count hit all-9s and was clamped
//   digitos   - BCD result, digit0 in [3:0]
//   db_estado - FSM state code (IDLE=0, ESPERA=1, MEDINDO=2, FIM=3)
module medidor_distancia_bcd #(
    parameter int R       = 2941,
    parameter int N       = 12,
    parameter int D       = 3,
    parameter int ARRED   = 1,
    parameter int TIMEOUT = 1250000
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           medir,
    input  logic           echo,
    output logic           pronto,
    output logic           timeout,
    output logic           saturado,
    output logic [4*D-1:0] digitos,
    output logic [2:0]     db_estado
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ESPERA  = 3'd1,
        MEDINDO = 3'd2,
        FIM     = 3'd3
    } estado_t;

    localparam int TW = $clog2(TIMEOUT + 1);

    // Decimal +1 with carry ripple; the caller handles the all-9s case.
    function automatic logic [4*D-1:0] bcd_inc(input logic [4*D-1:0] v);
        logic [4*D-1:0] r;
        logic           c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < D; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return r;
    endfunction

    estado_t        estado_q,    estado_d;
    logic           echo_m_q,    echo_m_d;
    logic           echo_s_q,    echo_s_d;
    logic           echo_p_q,    echo_p_d;
    logic [N-1:0]   prescaler_q, prescaler_d;
    logic [TW-1:0]  cnt_q,       cnt_d;
    logic [4*D-1:0] digitos_q,   digitos_d;
    logic           pronto_q,    pronto_d;
    logic           timeout_q,   timeout_d;
    logic           saturado_q,  saturado_d;

    logic           inc;
    logic           fin;
    logic           all9;

    assign all9 = (digitos_q == {D{4'h9}});

    always_comb begin
        estado_d    = estado_q;
        echo_m_d    = echo;
        echo_s_d    = echo_m_q;
        echo_p_d    = echo_s_q;
        prescaler_d = prescaler_q;
        cnt_d       = cnt_q;
        digitos_d   = digitos_q;
        pronto_d    = pronto_q;
        timeout_d   = timeout_q;
        saturado_d  = saturado_q;
        inc         = 1'b0;
        fin         = 1'b0;

        case (estado_q)
            IDLE, FIM: begin
                if (medir) begin
                    prescaler_d = '0;
                    cnt_d       = '0;
                    digitos_d   = '0;
                    pronto_d    = 1'b0;
                    timeout_d   = 1'b0;
                    saturado_d  = 1'b0;
                    estado_d    = ESPERA;
                end
            end
            ESPERA: begin
                cnt_d = cnt_q + TW'(1);
                // Only a true 0->1 transition starts a measurement, so an echo
                // already high when medir was accepted is ignored until it re-rises.
                if (echo_s_q && !echo_p_q) begin
                    prescaler_d = N'(1);
                    estado_d    = MEDINDO;
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    digitos_d = '0;
                    pronto_d  = 1'b1;
                    estado_d  = FIM;
                end
            end
            MEDINDO: begin
                if (echo_s_q) begin
                    if (prescaler_q == N'(R - 1)) begin
                        prescaler_d = '0;
                        inc         = 1'b1;
                    end else begin
                        prescaler_d = prescaler_q + N'(1);
                    end
                end else begin
                    // Fall cycle: prescaler holds the residue, no wrap can coincide.
                    if ((ARRED != 0) && (prescaler_q >= N'(R / 2))) begin
                        inc = 1'b1;
                    end
                    fin = 1'b1;
                end
                if (inc) begin
                    if (all9) begin
                        // Clamp and finish at once so a stuck-high echo cannot hang us.
                        saturado_d = 1'b1;
                        fin        = 1'b1;
                    end else begin
                        digitos_d = bcd_inc(digitos_q);
                    end
                end
                if (fin) begin
                    pronto_d = 1'b1;
                    estado_d = FIM;
                end
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q    <= IDLE;
            echo_m_q    <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_p_q    <= 1'b0;
            prescaler_q <= '0;
            cnt_q       <= '0;
            digitos_q   <= '0;
            pronto_q    <= 1'b0;
            timeout_q   <= 1'b0;
            saturado_q  <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            echo_m_q    <= echo_m_d;
            echo_s_q    <= echo_s_d;
            echo_p_q    <= echo_p_d;
            prescaler_q <= prescaler_d;
            cnt_q       <= cnt_d;
            digitos_q   <= digitos_d;
            pronto_q    <= pronto_d;
            timeout_q   <= timeout_d;
            saturado_q  <= saturado_d;
        end
    end

    assign pronto    = pronto_q;
    assign timeout   = timeout_q;
    assign saturado  = saturado_q;
    assign digitos   = digitos_q;
    assign db_estado = estado_q;

endmodule

// File: tb/tb_medidor_distancia_bcd.sv
module tb_medidor_distancia_bcd;

    logic       clock = 1'b0;
    logic       reset;
    logic       medir;
    logic       medir_b;
    logic       echo;

    logic       pronto,   pronto_b;
    logic       timeout,  timeout_b;
    logic       saturado, saturado_b;
    logic [7:0] digitos,  digitos_b;
    logic [2:0] db_estado, db_estado_b;

    always #5 clock = ~clock;

    medidor_distancia_bcd #(.R(10), .N(4), .D(2), .ARRED(1), .TIMEOUT(50)) dut_a (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir),
        .echo      (echo),
        .pronto    (pronto),
        .timeout   (timeout),
        .saturado  (saturado),
        .digitos   (digitos),
        .db_estado (db_estado)
    );

    medidor_distancia_bcd #(.R(10), .N(4), .D(2), .ARRED(0), .TIMEOUT(50)) dut_b (
        .clock     (clock),
        .reset     (reset),
        .medir     (medir_b),
        .echo      (echo),
        .pronto    (pronto_b),
        .timeout   (timeout_b),
        .saturado  (saturado_b),
        .digitos   (digitos_b),
        .db_estado (db_estado_b)
    );

    typedef struct packed {
        logic [7:0] dig;
        logic       sat;
        logic       to;
    } res_t;

    res_t exp_a_q[$];
    res_t exp_b_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every rising edge of a pronto consumes one expected result.
    initial begin
        logic prev_a;
        logic prev_b;
        res_t e;
        prev_a = 1'b0;
        prev_b = 1'b0;
        forever begin
            @(negedge clock);
            if (reset && pronto && !prev_a) begin
                if (exp_a_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pronto_a: got digitos=%0h with no expected result", digitos);
                end else begin
                    e = exp_a_q.pop_front();
                    check("a_digitos",  digitos,  e.dig);
                    check("a_saturado", saturado, e.sat);
                    check("a_timeout",  timeout,  e.to);
                end
            end
            if (reset && pronto_b && !prev_b) begin
                if (exp_b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pronto_b: got digitos=%0h with no expected result", digitos_b);
                end else begin
                    e = exp_b_q.pop_front();
                    check("b_digitos",  digitos_b,  e.dig);
                    check("b_saturado", saturado_b, e.sat);
                    check("b_timeout",  timeout_b,  e.to);
                end
            end
            prev_a = pronto;
            prev_b = pronto_b;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_pronto(input bit sel_b, input int budget, output int n);
        n = 0;
        while (((sel_b ? pronto_b : pronto) !== 1'b1) && (n < budget)) begin
            @(negedge clock);
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_pronto: got no pronto within %0d cycles, required pronto=1", budget);
        end
    endtask

    task automatic start_a();
        medir = 1'b1;
        cyc(1);
        medir = 1'b0;
        check("pronto_cleared_on_accept", pronto, 1'b0);
    endtask

    task automatic meas_a(input int k, input res_t e);
        int n;
        exp_a_q.push_back(e);
        start_a();
        cyc(2);
        echo = 1'b1;
        cyc(k);
        echo = 1'b0;
        wait_pronto(1'b0, 10, n);
        cyc(3);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_pronto"},    pronto,    1'b0);
        check({tag, "_timeout"},   timeout,   1'b0);
        check({tag, "_saturado"},  saturado,  1'b0);
        check({tag, "_digitos"},   digitos,   8'h00);
        check({tag, "_db_estado"}, db_estado, 3'd0);
    endtask

    initial begin
        int n;
        reset   = 1'b0;
        medir   = 1'b0;
        medir_b = 1'b0;
        echo    = 1'b0;
        cyc(3);
        check_zero("reset");
        reset = 1'b1;
        cyc(2);

        // Rounding up, and truncation below half a cm.
        meas_a(37, '{dig: 8'h04, sat: 1'b0, to: 1'b0});
        meas_a(34, '{dig: 8'h03, sat: 1'b0, to: 1'b0});

        // Truncating instance: 37 cycles -> 3 cm.
        exp_b_q.push_back('{dig: 8'h03, sat: 1'b0, to: 1'b0});
        medir_b = 1'b1;
        cyc(1);
        medir_b = 1'b0;
        cyc(2);
        echo = 1'b1;
        cyc(37);
        echo = 1'b0;
        wait_pronto(1'b1, 10, n);
        cyc(3);

        // Rounding from 99 saturates.
        meas_a(995, '{dig: 8'h99, sat: 1'b1, to: 1'b0});

        // Stuck-high echo: result must come out while echo is still high.
        exp_a_q.push_back('{dig: 8'h99, sat: 1'b1, to: 1'b0});
        start_a();
        echo = 1'b1;
        wait_pronto(1'b0, 1200, n);
        check("stuck_high_pronto_before_fall", (n < 1100), 1'b1);
        echo = 1'b0;
        cyc(5);

        // No echo at all: timeout after TIMEOUT clocks.
        exp_a_q.push_back('{dig: 8'h00, sat: 1'b0, to: 1'b1});
        medir = 1'b1;
        n = 0;
        while ((pronto !== 1'b1 || n < 2) && n < 100) begin
            @(negedge clock);
            n++;
            if (n == 1) medir = 1'b0;
        end
        check("timeout_latency_in_range", (n >= 50 && n <= 52), 1'b1);
        cyc(3);

        // Stale high echo at accept, then a real 20-cycle pulse; medir mid-pulse ignored.
        echo = 1'b1;
        cyc(4);
        exp_a_q.push_back('{dig: 8'h02, sat: 1'b0, to: 1'b0});
        start_a();
        cyc(5);
        check("stale_echo_still_waiting", db_estado, 3'd1);
        echo = 1'b0;
        cyc(5);
        echo = 1'b1;
        cyc(10);
        medir = 1'b1;
        cyc(1);
        medir = 1'b0;
        check("medir_ignored_in_medindo", db_estado, 3'd2);
        cyc(9);
        echo = 1'b0;
        wait_pronto(1'b0, 10, n);
        cyc(3);

        // Reset in the middle of a measurement.
        start_a();
        echo = 1'b1;
        cyc(8);
        check("pre_reset_medindo", db_estado, 3'd2);
        reset = 1'b0;
        #1;
        check_zero("async_reset");
        cyc(2);
        check_zero("held_reset");
        reset = 1'b1;
        cyc(2);
        check_zero("after_release");
        echo = 1'b0;
        cyc(5);
        check_zero("after_release_echo_fall");

        check("scoreboard_a_drained", exp_a_q.size(), 0);
        check("scoreboard_b_drained", exp_b_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
